byte_enable_memory: RTL

// Parametrised single-port data memory with per-byte write enables, registered read and hardware clear.

---
 rtl/byte_enable_memory_pkg.sv | 18 +
 rtl/byte_enable_memory_mem_clear_seq.sv | 38 +++
 rtl/byte_enable_memory.sv | 97 +++++++++
 3 files changed

// File: rtl/byte_enable_memory_pkg.sv
// Shared types and defaults for the byte-enable data memory and its clear sequencer.
package byte_enable_memory_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int unsigned DEF_DW    = 16;
    localparam int unsigned DEF_AW    = 8;
    localparam int unsigned DEF_DEPTH = 256;

    // Clear counter width; a single-word memory still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/byte_enable_memory_mem_clear_seq.sv
// Clear sequencer: walks word addresses 0..DEPTH-1, one per cycle, while busy.
module mem_clear_seq
    import byte_enable_memory_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic          start,
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic [CW-1:0] addr,
    output logic          done
);

    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    assign done = busy && (addr == LAST);

    // Comes out of reset busy so the array is always cleared before first use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b1;
            addr <= '0;
        end else if (start) begin
            busy <= 1'b1;
            addr <= '0;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
                addr <= '0;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_enable_memory.sv
// Single-port data memory with per-byte write enables, registered read and a hardware clear sequence.
module byte_enable_memory
    import byte_enable_memory_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [DW/8-1:0]     be,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       wdata,
    input  logic                clr,
    output logic                ready,
    output logic                rvalid,
    output logic [DW-1:0]       rdata,
    output logic                err
);

    localparam int unsigned BEW = DW / 8;
    localparam int unsigned CW  = cnt_width(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_t          state_q, state_d;
    logic            start;
    logic            busy;
    logic            done;
    logic [CW-1:0]   clr_addr;
    logic            acc;
    logic            in_range;
    logic [CW-1:0]   idx;
    logic [DW-1:0]   mem [DEPTH];

    mem_clear_seq #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_clear_seq (
        .start (start),
        .clk   (clk),
        .rst   (rst),
        .busy  (busy),
        .addr  (clr_addr),
        .done  (done)
    );

    assign ready    = (state_q == ST_IDLE);
    assign acc      = req && ready;
    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign idx      = addr[CW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_CLEAR;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_CLEAR: if (done) state_d = ST_IDLE;
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    start   = 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // The sequencer owns the write port while busy; accepts cannot occur then.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_addr] <= '0;
        end else if (acc && we && in_range) begin
            for (int unsigned i = 0; i < BEW; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= acc && !we;
            err    <= acc && !in_range;
            if (acc && !we) rdata <= in_range ? mem[idx] : '0;
        end
    end

endmodule
